// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC-3 memory arbiter and its two requesters plus the memory port.
// slave is the arbiter's view; master is the requester/memory side.
interface lc3_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rdy;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_rdy;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          grant_dma;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdy, cpu_rdata, dma_rdy, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant_dma
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdy, cpu_rdata, dma_rdy, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant_dma
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing the LC-3 memory port between the CPU and a DMA engine.
// Each grant runs a fixed MEM_LAT-cycle access followed by a one-cycle ready pulse.
module lc3_mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    lc3_mem_arbiter_if.slave  bus
);
    // state  | meaning
    // IDLE   | arbitrate between pending requests
    // ACCESS | drive latched request onto memory for MEM_LAT cycles
    // DONE   | one-cycle ready pulse to the owner
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateType;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    stateType      stateQ, stateNext;
    logic [CW-1:0] cntQ, cntNext;
    logic [DW-1:0] rdataQ;
    logic          lastGrantDma;
    logic          grantDmaQ;
    logic          weQ;
    logic [AW-1:0] addrQ;
    logic [DW-1:0] wdataQ;

    logic          doGrant;
    logic          grantSel;
    logic          captureRd;
    logic          memEn;
    logic          memWe;
    logic          cpuRdy;
    logic          dmaRdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateNext;
            cntQ   <= cntNext;
        end
    end

    always_comb begin
        stateNext = stateQ;
        cntNext   = cntQ;
        doGrant   = 1'b0;
        grantSel  = 1'b0;
        captureRd = 1'b0;
        memEn     = 1'b0;
        memWe     = 1'b0;
        cpuRdy    = 1'b0;
        dmaRdy    = 1'b0;
        case (stateQ)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    doGrant   = 1'b1;
                    // on a tie the requester that did not win last time goes first
                    grantSel  = (bus.cpu_req && bus.dma_req) ? ~lastGrantDma : bus.dma_req;
                    cntNext   = CNT_INIT;
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                memEn = 1'b1;
                memWe = weQ;
                if (cntQ != '0) begin
                    cntNext = cntQ - CW'(1);
                end else begin
                    captureRd = ~weQ;
                    stateNext = DONE;
                end
            end
            DONE: begin
                cpuRdy    = ~grantDmaQ;
                dmaRdy    = grantDmaQ;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdataQ       <= '0;
            lastGrantDma <= 1'b1;
            grantDmaQ    <= 1'b0;
            weQ          <= 1'b0;
            addrQ        <= '0;
            wdataQ       <= '0;
        end else begin
            if (doGrant) begin
                lastGrantDma <= grantSel;
                grantDmaQ    <= grantSel;
                weQ          <= grantSel ? bus.dma_we    : bus.cpu_we;
                addrQ        <= grantSel ? bus.dma_addr  : bus.cpu_addr;
                wdataQ       <= grantSel ? bus.dma_wdata : bus.cpu_wdata;
            end
            if (captureRd) begin
                rdataQ <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = addrQ;
    assign bus.mem_wdata = wdataQ;
    assign bus.cpu_rdy   = cpuRdy;
    assign bus.dma_rdy   = dmaRdy;
    assign bus.cpu_rdata = rdataQ;
    assign bus.dma_rdata = rdataQ;
    assign bus.busy      = (stateQ != IDLE);
    assign bus.grant_dma = grantDmaQ;
endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares the single LC-3 memory port between two requesters: the CPU control/datapath (MAR/MDR path) and a DMA/IO engine.
- Accepts level-held requests, arbitrates round-robin, and sequences a fixed-latency memory access.
- Returns a one-cycle ready pulse and read data to the winning requester.
- The pulse is the memRDY the CPU control FSM stalls on during its fetch, load, store, interrupt and trap states.

Parameters:
- MEM_LAT, 2: memory access cycles per transaction; legal range 1..15.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; held until cpu_rdy.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address (MAR).
- cpu_wdata  in  DW  CPU write data (MDR).
- cpu_rdy  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DW  read data; valid when cpu_rdy = 1.
- dma_req  in  1  DMA request; held until dma_rdy.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_rdy  out  1  one-cycle completion pulse to the DMA.
- dma_rdata  out  DW  read data; valid when dma_rdy = 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid on the last ACCESS cycle.
- busy  out  1  high whenever state is not IDLE.
- grant_dma  out  1  owner of the current or most recent transaction: 1 = DMA, 0 = CPU.

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock needed):
  - state = IDLE; cnt = 0; rdata_q = 0; last_grant = DMA, so the CPU wins the first tie.
  - All outputs = 0, including grant_dma.
- State IDLE:
  - Sample cpu_req and dma_req. If neither is set, stay in IDLE.
  - Only one requesting: grant it.
  - Both requesting: grant the requester that is not last_grant.
  - On a grant: latch owner, we, addr and wdata into internal registers; set last_grant = owner; set grant_dma = owner; cnt = MEM_LAT-1; go to ACCESS.
- State ACCESS:
  - mem_en = 1; mem_we = latched we; mem_addr and mem_wdata come from the latched registers only.
  - Requester inputs that change during ACCESS have no effect.
  - If cnt != 0: cnt decrements.
  - If cnt == 0 and the access is a read: capture mem_rdata into rdata_q, then go to DONE.
  - If cnt == 0 and the access is a write: leave rdata_q unchanged, then go to DONE.
  - mem_en is high for exactly MEM_LAT consecutive cycles per transaction.
- State DONE:
  - mem_en = 0; the owner's rdy = 1 for exactly one cycle; go to IDLE.
  - The other requester's rdy stays 0.
- Read data outputs:
  - cpu_rdata = dma_rdata = rdata_q at all times.
  - Meaningful only with the corresponding rdy; holds its value until the next read completes.
- Latency, from the IDLE cycle that samples the request:
  - mem_en in cycles 1..MEM_LAT; rdy in cycle MEM_LAT+1; next arbitration in cycle MEM_LAT+2.
  - Back-to-back transactions are therefore spaced MEM_LAT+2 cycles apart.
- Fairness:
  - With both requests held, grants strictly alternate.
  - A waiting requester is served within one transaction.
- Request dropped mid-transaction (protocol violation):
  - The transaction still completes and rdy still pulses.
  - No abort path exists.
- A request still high in the cycle after DONE is treated as a new request.
- Reset during ACCESS or DONE:
  - mem_en, mem_we and rdy drop immediately.
  - No rdy pulse is issued for the aborted transaction.
- Counter: width is enough to hold MEM_LAT-1; it never wraps because it is only reloaded in IDLE.
- busy is combinational: (state != IDLE).

Test Plan:
- MEM_LAT = 2, CPU read: cpu_req = 1, cpu_addr = 0x3000 sampled in cycle 0; model returns 0x1234. Required:
  - mem_en = 1 with mem_addr = 0x3000 in cycles 1-2.
  - cpu_rdy = 1 and cpu_rdata = 0x1234 in cycle 3 only.
  - dma_rdy = 0 throughout; busy = 1 in cycles 1-3.
- After reset, both requests held continuously: grants go CPU, DMA, CPU, DMA.
  - grant_dma = 0, 1, 0, 1.
  - Successive rdy pulses are 4 cycles apart.
- DMA write: addr 0x4000, data 0xBEEF, with rdata_q = 0x1234 beforehand. Required:
  - mem_we = 1, mem_addr = 0x4000, mem_wdata = 0xBEEF for both ACCESS cycles.
  - dma_rdy pulses once; cpu_rdata/dma_rdata stay 0x1234.
- CPU read granted, then cpu_addr changed to 0xFFFF and cpu_req dropped in cycle 1. Required:
  - mem_addr stays 0x3000.
  - cpu_rdy still pulses in cycle 3.
- rst asserted in the second ACCESS cycle. Required:
  - mem_en = 0 and busy = 0 immediately; no rdy pulse.
  - After release with both requests high, the CPU is granted first.
- MEM_LAT = 1 build: read completes with mem_en high for 1 cycle and rdy in cycle 2.
